// File: rtl/brq_loader_pkg.sv
// rtl/brq_loader_pkg.sv - shared types and constants for the ICCM boot loader
//
// Purpose: FSM state encoding, frame sync marker and ICCM capacity helper.
package brq_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        WRITE,
        CSUM,
        DONE,
        ERROR
    } loader_state_e;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // Number of 32-bit words addressable with a byte address of addr_width bits.
    function automatic int unsigned max_words(input int unsigned addr_width);
        return 32'd1 << (addr_width - 2);
    endfunction

endpackage

// File: rtl/brq_word_packer.sv
// rtl/brq_word_packer.sv - little-endian byte to 32-bit word assembler
//
// Purpose: shifts received bytes into a 32-bit word, lowest byte first.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   clear_i         restart at byte 0 with an all-zero word
//   shift_i         accept byte_i into the current byte lane
//   byte_i          incoming byte
//   word_o          word assembled so far
//   word_full_o     the byte being shifted this cycle completes the word
module brq_word_packer (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic        shift_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_full_o
);

    logic [31:0] word_q, word_d;
    logic [1:0]  idx_q, idx_d;

    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        if (clear_i) begin
            word_d = '0;
            idx_d  = '0;
        end else if (shift_i) begin
            word_d[{idx_q, 3'b000} +: 8] = byte_i;
            idx_d                       = idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_q <= '0;
            idx_q  <= '0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
        end
    end

    assign word_o      = word_q;
    assign word_full_o = shift_i && !clear_i && (idx_q == 2'd3);

endmodule

// File: rtl/iccm_loader.sv
// rtl/iccm_loader.sv - framed UART image loader driving the ICCM write port
//
// Purpose: parses sync / 16-bit length / little-endian words / XOR checksum,
// writes words to consecutive ICCM addresses and holds the core in reset
// until the image has loaded with a matching checksum.
// Ports:
//   brq_clk, brq_rst        clock, asynchronous active-low reset
//   rx_valid, rx_data       byte stream from the UART receiver
//   rx_ready                loader accepts rx_data this cycle
//   iccm_write              single-cycle write strobe
//   iccm_addr, iccm_wdata   write address (word aligned) and data
//   words_loaded            words written so far
//   load_done, load_error   sticky completion / fault flags
//   core_hold               core reset hold, released on load_done
module iccm_loader
    import brq_loader_pkg::*;
#(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AddrWidth = 15,
    parameter logic [7:0]  SyncByte  = SYNC_BYTE
) (
    input  logic                 brq_clk,
    input  logic                 brq_rst,
    input  logic                 rx_valid,
    input  logic [7:0]           rx_data,
    output logic                 rx_ready,
    output logic                 iccm_write,
    output logic [AddrWidth-1:0] iccm_addr,
    output logic [DataWidth-1:0] iccm_wdata,
    output logic [15:0]          words_loaded,
    output logic                 load_done,
    output logic                 load_error,
    output logic                 core_hold
);

    localparam logic [16:0] MaxWords = 17'(max_words(AddrWidth));

    loader_state_e        state_q, state_d;
    logic [15:0]          len_q, len_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [15:0]          count_q, count_d;
    logic [7:0]           csum_q, csum_d;

    logic        accept;
    logic        word_full;
    logic [31:0] word;
    logic [15:0] len_rx;

    assign rx_ready = (state_q == IDLE) || (state_q == LEN_LO) || (state_q == LEN_HI)
                   || (state_q == DATA) || (state_q == CSUM);
    assign accept   = rx_valid && rx_ready;
    assign len_rx   = {rx_data, len_q[7:0]};

    brq_word_packer u_packer (
        .clk_i       (brq_clk),
        .rst_ni      (brq_rst),
        .clear_i     (accept && (state_q == LEN_HI)),
        .shift_i     (accept && (state_q == DATA)),
        .byte_i      (rx_data),
        .word_o      (word),
        .word_full_o (word_full)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        addr_d  = addr_q;
        count_d = count_q;
        csum_d  = csum_q;
        unique case (state_q)
            IDLE: begin
                if (accept && rx_data == SyncByte) state_d = LEN_LO;
            end
            LEN_LO: begin
                if (accept) begin
                    len_d[7:0] = rx_data;
                    state_d    = LEN_HI;
                end
            end
            LEN_HI: begin
                if (accept) begin
                    len_d[15:8] = rx_data;
                    if ({1'b0, len_rx} > MaxWords) state_d = ERROR;
                    else if (len_rx == 16'd0)      state_d = CSUM;
                    else                           state_d = DATA;
                end
            end
            DATA: begin
                if (accept) begin
                    csum_d = csum_q ^ rx_data;
                    if (word_full) state_d = WRITE;
                end
            end
            WRITE: begin
                addr_d  = addr_q + AddrWidth'(4);
                count_d = count_q + 16'd1;
                state_d = (count_q + 16'd1 == len_q) ? CSUM : DATA;
            end
            CSUM: begin
                if (accept) state_d = (rx_data == csum_q) ? DONE : ERROR;
            end
            DONE:    state_d = DONE;
            ERROR:   state_d = ERROR;
            default: state_d = ERROR;
        endcase
    end

    always_ff @(posedge brq_clk or negedge brq_rst) begin
        if (!brq_rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            addr_q  <= '0;
            count_q <= '0;
            csum_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            csum_q  <= csum_d;
        end
    end

    assign iccm_write   = (state_q == WRITE);
    assign iccm_addr    = addr_q;
    assign iccm_wdata   = DataWidth'(word);
    assign words_loaded = count_q;
    assign load_done    = (state_q == DONE);
    assign load_error   = (state_q == ERROR);
    // Released combinationally from the DONE state so it falls with load_done.
    assign core_hold    = (state_q != DONE);

endmodule

// File: tb/tb_iccm_loader.sv
// tb/tb_iccm_loader.sv - scoreboard bench for iccm_loader
module tb_iccm_loader;

    logic        brq_clk = 1'b0;
    logic        brq_rst = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready;
    logic        iccm_write;
    logic [14:0] iccm_addr;
    logic [31:0] iccm_wdata;
    logic [15:0] words_loaded;
    logic        load_done;
    logic        load_error;
    logic        core_hold;

    int tests = 0;
    int fails = 0;
    int stalls = 0;
    logic [46:0] exp_q[$];

    iccm_loader dut (
        .brq_clk      (brq_clk),
        .brq_rst      (brq_rst),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .iccm_write   (iccm_write),
        .iccm_addr    (iccm_addr),
        .iccm_wdata   (iccm_wdata),
        .words_loaded (words_loaded),
        .load_done    (load_done),
        .load_error   (load_error),
        .core_hold    (core_hold)
    );

    always #5 brq_clk = ~brq_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the head of the scoreboard.
    initial begin
        logic [46:0] e;
        forever begin
            @(negedge brq_clk);
            if (iccm_write) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected",
                             iccm_addr, iccm_wdata);
                end else begin
                    e = exp_q.pop_front();
                    if (iccm_addr !== e[46:32] || iccm_wdata !== e[31:0]) begin
                        fails++;
                        $display("FAIL write: got 0x%0h@0x%0h expected 0x%0h@0x%0h",
                                 iccm_wdata, iccm_addr, e[31:0], e[46:32]);
                    end
                end
            end
        end
    end

    // Leaves rx_valid high so consecutive bytes form a continuous stream.
    task automatic send_byte(input logic [7:0] b);
        int waits = 0;
        @(negedge brq_clk);
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && waits < 20) begin
            @(negedge brq_clk);
            waits++;
        end
        stalls += waits;
        if (!rx_ready) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: byte 0x%0h not accepted, rx_ready %0b", b, rx_ready);
        end
        @(posedge brq_clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] bytes[$]);
        foreach (bytes[i]) send_byte(bytes[i]);
    endtask

    task automatic apply_reset();
        rx_valid = 1'b0;
        brq_rst  = 1'b0;
        repeat (2) @(negedge brq_clk);
        brq_rst = 1'b1;
        @(negedge brq_clk);
    endtask

    task automatic chk_status(input string tag, input logic done, input logic err,
                              input logic [15:0] words);
        chk({tag, "_done"}, 32'(load_done), 32'(done));
        chk({tag, "_error"}, 32'(load_error), 32'(err));
        chk({tag, "_hold"}, 32'(core_hold), 32'(!done));
        chk({tag, "_words"}, 32'(words_loaded), 32'(words));
        chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        apply_reset();
        chk("reset_ready", 32'(rx_ready), 32'd1);
        chk("reset_addr", 32'(iccm_addr), 32'd0);
        chk("reset_wdata", iccm_wdata, 32'd0);
        chk_status("reset", 1'b0, 1'b0, 16'd0);

        // Clean 2-word load
        exp_q.push_back({15'h0000, 32'h0000_0013});
        exp_q.push_back({15'h0004, 32'h0000_006F});
        send_frame('{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                     8'h6F, 8'h00, 8'h00, 8'h00, 8'h7C});
        chk_status("two_word", 1'b1, 1'b0, 16'd2);
        chk("two_word_addr", 32'(iccm_addr), 32'h8);

        // Zero length, good and bad checksum
        apply_reset();
        send_frame('{8'hA5, 8'h00, 8'h00, 8'h00});
        chk_status("zero_len", 1'b1, 1'b0, 16'd0);
        apply_reset();
        send_frame('{8'hA5, 8'h00, 8'h00, 8'h01});
        chk_status("zero_len_bad", 1'b0, 1'b1, 16'd0);
        chk("zero_len_bad_ready", 32'(rx_ready), 32'd0);

        // Noise before sync
        apply_reset();
        exp_q.push_back({15'h0000, 32'h1234_5678});
        send_frame('{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h00,
                     8'h78, 8'h56, 8'h34, 8'h12, 8'h08});
        chk_status("noise", 1'b1, 1'b0, 16'd1);

        // Oversize length 8193
        apply_reset();
        send_frame('{8'hA5, 8'h01, 8'h20});
        chk_status("oversize", 1'b0, 1'b1, 16'd0);
        chk("oversize_ready", 32'(rx_ready), 32'd0);

        // Maximum length is accepted (header only, then abandoned)
        apply_reset();
        send_frame('{8'hA5, 8'h00, 8'h20});
        chk("max_len_error", 32'(load_error), 32'd0);
        chk("max_len_ready", 32'(rx_ready), 32'd1);

        // Back-pressure: continuous valid through a 3-word frame
        apply_reset();
        exp_q.push_back({15'h0000, 32'h0403_0201});
        exp_q.push_back({15'h0004, 32'h4030_2010});
        exp_q.push_back({15'h0008, 32'hDDCC_BBAA});
        stalls = 0;
        send_frame('{8'hA5, 8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
                     8'h10, 8'h20, 8'h30, 8'h40, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h44});
        chk("bp_stalls", 32'(stalls), 32'd3);
        chk_status("bp", 1'b1, 1'b0, 16'd3);

        // Reset mid-load after 5 data bytes
        apply_reset();
        exp_q.push_back({15'h0000, 32'h0403_0201});
        send_frame('{8'hA5, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05});
        chk("mid_pre_words", 32'(words_loaded), 32'd1);
        #2;
        rx_valid = 1'b0;
        brq_rst  = 1'b0;
        #1;
        chk("mid_rst_write", 32'(iccm_write), 32'd0);
        chk("mid_rst_addr", 32'(iccm_addr), 32'd0);
        chk("mid_rst_wdata", iccm_wdata, 32'd0);
        chk_status("mid_rst", 1'b0, 1'b0, 16'd0);
        @(negedge brq_clk);
        brq_rst = 1'b1;
        @(negedge brq_clk);
        exp_q.push_back({15'h0000, 32'hDEAD_BEEF});
        send_frame('{8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22});
        chk_status("after_rst", 1'b1, 1'b0, 16'd1);

        repeat (3) @(negedge brq_clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/iccm_loader.md
Name: iccm_loader

Overview:
- Boot-time program loader directly upstream of the instruction memory (ICCM); drives its write port.
- Accepts a byte stream from a UART receiver with a valid/ready handshake.
- Parses a framed image: sync byte, 16-bit word count, little-endian instruction words, XOR checksum.
- Writes the words to consecutive ICCM addresses and holds the core in reset until the load completes cleanly.

Parameters:
- DataWidth, 32, ICCM word width; fixed at 32 (4 bytes per word).
- AddrWidth, 15, ICCM byte-address width; capacity MAX_WORDS = 2^(AddrWidth-2) = 8192.
- SyncByte, 8'hA5, frame start marker.

Ports:
- brq_clk  in  1  system clock.
- brq_rst  in  1  reset, asynchronous, active-low.
- rx_valid  in  1  byte available from the UART receiver.
- rx_data  in  8  received byte.
- rx_ready  out  1  loader accepts rx_data this cycle.
- iccm_write  out  1  single-cycle ICCM write strobe.
- iccm_addr  out  AddrWidth  ICCM byte address, bits [1:0] always 0.
- iccm_wdata  out  DataWidth  assembled instruction word.
- words_loaded  out  16  count of words written so far.
- load_done  out  1  image loaded and checksum matched; sticky.
- load_error  out  1  framing, length or checksum fault; sticky.
- core_hold  out  1  holds the core in reset; 1 until load_done.

Behaviour:
- Byte transfer occurs on a rising edge with rx_valid && rx_ready.
- rx_ready = 1 in IDLE, LEN_LO, LEN_HI, DATA, CSUM; 0 in WRITE, DONE, ERROR.
- Reset (brq_rst=0, any time, including mid-load):
  - state=IDLE; iccm_write=0, iccm_addr=0, iccm_wdata=0, words_loaded=0.
  - load_done=0, load_error=0, core_hold=1, checksum accumulator=0, byte index=0.
- Partially written ICCM contents are not cleared on reset; a new frame overwrites them.
- States and transitions:
  - IDLE: byte==SyncByte -> LEN_LO; any other byte is discarded and the state stays IDLE.
  - LEN_LO: latch len[7:0] -> LEN_HI.
  - LEN_HI: latch len[15:8]. If len > MAX_WORDS -> ERROR. If len == 0 -> CSUM. Otherwise -> DATA.
  - DATA: bytes fill word bits [7:0], [15:8], [23:16], [31:24] in order (little-endian). Each byte is XORed into csum. The 4th byte -> WRITE.
  - WRITE: lasts exactly one cycle. iccm_write=1 with iccm_addr and iccm_wdata stable. On exit: iccm_addr += 4, words_loaded += 1. If words_loaded+1 == len -> CSUM, else -> DATA.
  - CSUM: byte == csum -> DONE; mismatch -> ERROR.
  - DONE: load_done=1; core_hold deasserts in the same cycle load_done rises. Terminal until reset.
  - ERROR: load_error=1, core_hold stays 1, rx_ready=0. Terminal until reset.
- Latency: 4th data byte accepted at edge N -> iccm_write high for cycle N..N+1 -> new address visible after edge N+1.
- A byte presented during WRITE is back-pressured (rx_ready=0) and accepted in the following DATA cycle; no byte is lost.
- iccm_addr never wraps: the length check guarantees the last write address is (MAX_WORDS-1)*4.
- The header bytes (sync, length) are not included in the checksum.
- iccm_write is never asserted outside the WRITE state.

Decomposition:
- Package brq_loader_pkg holds:
  - state enum: IDLE, LEN_LO, LEN_HI, DATA, WRITE, CSUM, DONE, ERROR.
  - SYNC_BYTE constant.
  - MAX_WORDS derivation function.
- One sub-module, brq_word_packer: byte shift-in, 2-bit byte index, word_full flag, clear input. The FSM and address/count logic stay in iccm_loader.

Test Plan:
- Clean 2-word load: A5, 02, 00, 13,00,00,00, 6F,00,00,00, 7C.
  - Writes 0x00000013 @0x0000 and 0x0000006F @0x0004.
  - words_loaded=2, load_done=1, core_hold=0.
- Zero length: A5, 00, 00, 00 -> no iccm_write, load_done=1. Same frame with checksum byte 01 -> load_error=1, core_hold=1.
- Noise before sync: 00, FF, 5A, then a valid 1-word frame -> junk bytes ignored, single write @0x0000.
- Oversize length: A5, 01, 20 (len=8193) -> ERROR after the LEN_HI byte, rx_ready=0, no writes.
- Back-pressure: rx_valid held high continuously through a 3-word frame.
  - rx_ready drops for exactly one cycle per WRITE.
  - All 12 data bytes land correctly at 0x0000, 0x0004, 0x0008.
- Reset mid-load: assert brq_rst=0 after 5 data bytes.
  - Outputs return to reset values asynchronously.
  - A subsequent clean 1-word frame writes @0x0000 and completes with load_done=1.
